inst_stream_loader: RTL and testbench

- Writer for the instruction memory's program-load port (lden / load address / load data).
- Accepts a byte stream over a valid/ready handshake, typically from the UART receiver.
- Assembles little-endian 32-bit words and issues one single-cycle load write per word at consecutive word addresses.
- Holds the CPU in reset for the whole load.

---
 rtl/inst_stream_loader.sv | 200 ++++++++++++++++++++
 tb/tb_inst_stream_loader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_stream_loader.sv
// inst_stream_loader: turns a byte stream (valid/ready) into program-load
// writes for the instruction memory. A session is a 4-byte little-endian word
// count N followed by N little-endian 32-bit words. Each word is written with
// a single-cycle ld_en pulse at consecutive word addresses from base_addr.
// The CPU is held in reset while a session runs, and also after a failed one.
//
// Optional build macro: LOADER_CHECKSUM_EN
//   When defined, a trailing check byte (XOR of all data bytes) is expected
//   after the last word. A mismatch ends the session in the error state.
//   Words already written are not rolled back.
module inst_stream_loader #(
    parameter int                    word_width      = 32,
    parameter int                    inst_addr_width = 12,
    parameter logic [word_width-1:0] base_addr       = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_valid,
    output logic                       rx_ready,
    output logic                       ld_en,
    output logic [word_width-1:0]      ld_addr,
    output logic [word_width-1:0]      ld_data,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic                       cpu_hold,
    output logic [inst_addr_width-2:0] words_loaded
);

    localparam int              WL_W     = inst_addr_width - 1;
    // Number of words the instruction memory can hold.
    localparam logic [31:0]     CAPACITY = 32'd1 << (inst_addr_width - 2);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_CHK   = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;
`endif

    state_t             state;
    state_t             state_next;
    logic [1:0]         byte_cnt;
    logic [31:0]        shreg;
    logic [31:0]        n_words;
    logic [WL_W-1:0]    wl_q;
    logic [word_width-1:0] addr_q;
    logic [word_width-1:0] data_q;

    logic               xfer;
    logic               last_byte;
    logic               enter_hdr;
    logic [31:0]        assembled;
    logic [31:0]        wl_plus1;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0]         csum;
`endif

    // A byte moves only when both sides agree; the 4th byte completes a word.
    assign xfer      = rx_valid && rx_ready;
    assign last_byte = xfer && (byte_cnt == 2'd3);
    // Bytes arrive LSB first, so shifting in from the top leaves byte 0 in [7:0].
    assign assembled = {rx_data, shreg[31:8]};
    assign wl_plus1  = 32'(wl_q) + 32'd1;
    // A new session may only start from an idle or finished state.
    assign enter_hdr = start && (state == S_IDLE || state == S_DONE || state == S_ERR);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start) state_next = S_HDR;
            S_HDR: begin
                if (last_byte) begin
                    if (assembled == 32'd0)       state_next = S_DONE;
                    else if (assembled > CAPACITY) state_next = S_ERR;
                    else                          state_next = S_DATA;
                end
            end
            S_DATA: if (last_byte) state_next = S_WRITE;
            S_WRITE: begin
                if (wl_plus1 < n_words) state_next = S_DATA;
`ifdef LOADER_CHECKSUM_EN
                else                    state_next = S_CHK;
`else
                else                    state_next = S_DONE;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: if (xfer) state_next = (rx_data == csum) ? S_DONE : S_ERR;
`endif
            S_DONE: if (start) state_next = S_HDR;
            S_ERR:  if (start) state_next = S_HDR;
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs decoded purely from the current state.
    always_comb begin
        rx_ready = 1'b0;
        ld_en    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        cpu_hold = 1'b0;
        case (state)
            S_HDR, S_DATA: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                cpu_hold = 1'b1;
            end
            S_WRITE: begin
                ld_en    = 1'b1;
                busy     = 1'b1;
                cpu_hold = 1'b1;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                cpu_hold = 1'b1;
            end
`endif
            S_DONE: done = 1'b1;
            S_ERR: begin
                error    = 1'b1;
                cpu_hold = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: byte assembly, header capture, write address/data, word count.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt <= '0;
            shreg    <= '0;
            n_words  <= '0;
            wl_q     <= '0;
            addr_q   <= '0;
            data_q   <= '0;
        end else if (enter_hdr) begin
            byte_cnt <= '0;
            shreg    <= '0;
            n_words  <= '0;
            wl_q     <= '0;
        end else begin
            if (xfer && (state == S_HDR || state == S_DATA)) begin
                shreg    <= assembled;
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (last_byte && state == S_HDR)
                n_words <= assembled;
            // Latch the write at the 4th data byte so it is stable for the
            // whole WRITE cycle and holds afterwards.
            if (last_byte && state == S_DATA) begin
                data_q <= assembled;
                addr_q <= base_addr + word_width'({wl_q, 2'b00});
            end
            if (state == S_WRITE)
                wl_q <= wl_q + 1'b1;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running XOR over data-phase bytes only; the header is not covered.
    always_ff @(posedge clk) begin
        if (reset || enter_hdr)               csum <= '0;
        else if (xfer && state == S_DATA)     csum <= csum ^ rx_data;
    end
`endif

    assign ld_addr      = addr_q;
    assign ld_data      = data_q;
    assign words_loaded = wl_q;

endmodule

// File: tb/tb_inst_stream_loader.sv
// Bench for inst_stream_loader: table of sessions plus hand-written corner
// sequences; expected writes go into a queue and are popped by a write monitor.
module tb_inst_stream_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready, ld_en, busy, done, error, cpu_hold;
    logic [31:0] ld_addr, ld_data;
    logic [10:0] words_loaded;

    inst_stream_loader dut (
        .clk(clk), .reset(reset), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .busy(busy), .done(done), .error(error), .cpu_hold(cpu_hold),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [31:0] n;
        int          seed;
        bit          gaps;
        bit          exp_err;
        int          exp_loaded;
    } vec_t;

    wr_t         exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    bit          use_gaps = 1'b0;
    logic [31:0] mem [0:1023];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Instruction memory model fed by the load port.
    always @(posedge clk) if (ld_en === 1'b1) mem[ld_addr[11:2]] <= ld_data;

    // Write monitor: every ld_en pulse must match the oldest expected write.
    always @(negedge clk) begin : mon
        wr_t e;
        if (ld_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %h data %h expected none", ld_addr, ld_data);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", ld_addr, e.addr);
                chk("wr_data", ld_data, e.data);
                chk("rdy_in_write", {31'd0, rx_ready}, 32'd0);
            end
        end
    end

    function automatic logic [31:0] wdata(input int seed, input int i);
        if (seed == 0) return (i == 0) ? 32'h00000013 : 32'hDEADBEEF;
        if (seed == 1) return 32'hDDCCBBAA;
        return (32'(seed) * 32'h9E3779B1) ^ (32'(i) * 32'h01000193) ^ 32'(i);
    endfunction

    // Offer one byte, optionally after 0-3 idle cycles; returns just after the
    // clock edge on which it was consumed.
    task automatic send_byte(input logic [7:0] b);
        int cnt;
        if (use_gaps) begin
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                rx_valid = 1'b0;
            end
        end
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        cnt = 0;
        while (rx_ready !== 1'b1 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        if (rx_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL rx_ready_timeout: got %b expected 1", rx_ready);
        end
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end();
        int cnt = 0;
        while (done !== 1'b1 && error !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        #1;
        chk("end_timeout", {31'd0, (done === 1'b1 || error === 1'b1)}, 32'd1);
    endtask

    task automatic run_row(input vec_t v);
        logic [31:0] w;
        logic [7:0]  x = 8'h00;
        use_gaps = v.gaps;
        pulse_start();
        chk("hdr_busy", {31'd0, busy}, 32'd1);
        chk("hdr_hold", {31'd0, cpu_hold}, 32'd1);
        chk("hdr_wl_clear", {21'd0, words_loaded}, 32'd0);
        send_word(v.n);
        if (v.n == 32'd0) begin
            chk("zero_done_next", {31'd0, done}, 32'd1);
            chk("zero_hold", {31'd0, cpu_hold}, 32'd0);
        end else if (v.exp_err) begin
            chk("ovs_error", {31'd0, error}, 32'd1);
            chk("ovs_hold", {31'd0, cpu_hold}, 32'd1);
            chk("ovs_busy", {31'd0, busy}, 32'd0);
        end else begin
            for (int i = 0; i < int'(v.n); i++) begin
                w = wdata(v.seed, i);
                x = x ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
                exp_q.push_back('{addr: 32'(i) * 32'd4, data: w});
                send_word(w);
                chk("ld_en_after_4th", {31'd0, ld_en}, 32'd1);
                chk("rdy_low_write", {31'd0, rx_ready}, 32'd0);
            end
            chk("hold_before_done", {31'd0, cpu_hold}, 32'd1);
`ifdef LOADER_CHECKSUM_EN
            send_byte(x);
`endif
            wait_end();
            chk("done", {31'd0, done}, 32'd1);
            chk("error_clear", {31'd0, error}, 32'd0);
            chk("hold_released", {31'd0, cpu_hold}, 32'd0);
            chk("busy_end", {31'd0, busy}, 32'd0);
        end
        chk("words_loaded", {21'd0, words_loaded}, 32'(v.exp_loaded));
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        use_gaps = 1'b0;
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{32'd2,           0, 1'b0, 1'b0, 2};    // basic load
        vecs[1] = '{32'd2,           0, 1'b1, 1'b0, 2};    // same with stalls
        vecs[2] = '{32'd0,           0, 1'b0, 1'b0, 0};    // zero length
        vecs[3] = '{32'd1025,        0, 1'b0, 1'b1, 0};    // one past capacity
        vecs[4] = '{32'd1,           1, 1'b0, 1'b0, 1};    // recover after error
        vecs[5] = '{32'h0001_0000,   0, 1'b1, 1'b1, 0};    // far oversize
        vecs[6] = '{32'd3,           5, 1'b1, 1'b0, 3};
        vecs[7] = '{32'd1024,        7, 1'b0, 1'b0, 1024}; // exact capacity

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ld_en", {31'd0, ld_en}, 32'd0);
        chk("rst_outs", {26'd0, rx_ready, busy, done, error, cpu_hold, 1'b0}, 32'd0);
        chk("rst_addr", ld_addr, 32'd0);
        chk("rst_data", ld_data, 32'd0);
        reset = 1'b0;

        // Bytes offered while idle must not be consumed.
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        #1 chk("idle_not_ready", {31'd0, rx_ready}, 32'd0);
        @(negedge clk);
        rx_valid = 1'b0;

        for (int r = 0; r < 8; r++) run_row(vecs[r]);

        // Reset in the middle of a word, with a stray start while busy.
        pulse_start();
        send_word(32'd2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_q.push_back('{addr: 32'h0, data: 32'h11223344});
        send_word(32'h11223344);
        chk("start_ignored", {31'd0, busy}, 32'd1);
        send_byte(8'hA1);
        send_byte(8'hA2);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_outs", {26'd0, rx_ready, busy, done, error, cpu_hold, ld_en}, 32'd0);
        chk("mid_rst_wl", {21'd0, words_loaded}, 32'd0);
        chk("mid_rst_addr", ld_addr, 32'd0);
        chk("mid_rst_data", ld_data, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_q", 32'(exp_q.size()), 32'd0);
        run_row('{32'd1, 1, 1'b0, 1'b0, 1});

`ifdef LOADER_CHECKSUM_EN
        // Correct and corrupted check byte for data 01 02 04 08.
        for (int t = 0; t < 2; t++) begin
            pulse_start();
            send_word(32'd1);
            exp_q.push_back('{addr: 32'h0, data: 32'h08040201});
            send_word(32'h08040201);
            send_byte(t == 0 ? 8'h0F : 8'h0E);
            wait_end();
            chk("chk_done", {31'd0, done}, (t == 0) ? 32'd1 : 32'd0);
            chk("chk_error", {31'd0, error}, (t == 0) ? 32'd0 : 32'd1);
            chk("chk_hold", {31'd0, cpu_hold}, (t == 0) ? 32'd0 : 32'd1);
            chk("chk_mem", mem[0], 32'h08040201);
        end
`endif

        repeat (3) @(negedge clk);
        chk("final_queue", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
